// File: rtl/dds_step_controller.sv
// DDS frequency-word controller: debounced panel keys and a sawtooth sweep
// request updates of the step word, which is published over valid/ready.
module dds_step_controller #(
  parameter int unsigned STEP_INIT = 171798691,
  parameter int unsigned STEP_MAX  = 171798691,
  parameter int unsigned STEP_MIN  = 858993,
  parameter int unsigned D_COARSE  = 858993,
  parameter int unsigned D_MICRO   = 85899,
  parameter int unsigned D_NANO    = 85,
  parameter int unsigned DB_CYCLES = 500000,
  parameter int unsigned SWEEP_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  key_n,
  input  logic        sweep_en,
  input  logic        step_ready,
  output logic [31:0] step,
  output logic        step_valid
);

  localparam int unsigned NKEY = 6;
  localparam int unsigned NREQ = 7;
  localparam int unsigned DBW  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int unsigned SWW  = (SWEEP_DIV > 1) ? $clog2(SWEEP_DIV) : 1;
  localparam logic [2:0]  OP_SWEEP = 3'd6;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] PUB  = 2'd2;

  logic [NKEY-1:0] key_s1, key_s2, key_st, key_fall_c, pend;
  logic [DBW-1:0]  db_cnt [NKEY];
  logic [SWW-1:0]  sw_cnt;
  logic            pend_sw, sw_tick_c;
  logic [NREQ-1:0] req_c, grant_c;
  logic [1:0]      state, state_nxt;
  logic [2:0]      op, op_nxt;
  logic [31:0]     step_nxt;
  logic            valid_nxt, found;
  logic [32:0]     step_w, delta_w, sum_w, result_c;

  // Key synchronizer, debounce and press detection
  always_comb begin
    key_fall_c = '0;
    for (int i = 0; i < NKEY; i++) begin
      key_fall_c[i] = key_st[i] && !key_s2[i] && (db_cnt[i] == DBW'(DB_CYCLES - 1));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_s1 <= '1;
      key_s2 <= '1;
      key_st <= '1;
      pend   <= '0;
      for (int i = 0; i < NKEY; i++) db_cnt[i] <= '0;
    end else begin
      key_s1 <= key_n;
      key_s2 <= key_s1;
      for (int i = 0; i < NKEY; i++) begin
        if (key_s2[i] != key_st[i]) begin
          if (db_cnt[i] == DBW'(DB_CYCLES - 1)) begin
            key_st[i] <= key_s2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DBW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
      pend <= (pend & ~grant_c[NKEY-1:0]) | key_fall_c;
    end
  end

  // Sweep divider
  assign sw_tick_c = sweep_en && (sw_cnt == SWW'(SWEEP_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_cnt  <= '0;
      pend_sw <= 1'b0;
    end else if (!sweep_en) begin
      sw_cnt  <= '0;
      pend_sw <= 1'b0;
    end else begin
      sw_cnt  <= sw_tick_c ? '0 : sw_cnt + SWW'(1);
      pend_sw <= (pend_sw & ~grant_c[NREQ-1]) | sw_tick_c;
    end
  end

  // Step arithmetic in 33 bits so overflow past STEP_MAX is visible
  always_comb begin
    step_w = {1'b0, step};
    case (op[2:1])
      2'd1:    delta_w = 33'(D_MICRO);
      2'd2:    delta_w = 33'(D_NANO);
      default: delta_w = 33'(D_COARSE);
    endcase
    sum_w = step_w + delta_w;
    if (op == OP_SWEEP) begin
      result_c = (sum_w > 33'(STEP_MAX)) ? 33'(STEP_MIN) : sum_w;
    end else if (!op[0]) begin
      result_c = (sum_w > 33'(STEP_MAX)) ? 33'(STEP_MAX) : sum_w;
    end else begin
      result_c = (step_w < 33'(STEP_MIN) + delta_w) ? 33'(STEP_MIN) : step_w - delta_w;
    end
  end

  assign req_c = {pend_sw, pend};

  // Next state, fixed-priority grant and publish control
  always_comb begin
    state_nxt = state;
    op_nxt    = op;
    step_nxt  = step;
    valid_nxt = step_valid;
    grant_c   = '0;
    found     = 1'b0;
    case (state)
      IDLE: begin
        for (int i = 0; i < NREQ; i++) begin
          if (req_c[i] && !found) begin
            found      = 1'b1;
            grant_c[i] = 1'b1;
            op_nxt     = 3'(i);
          end
        end
        if (found) state_nxt = CALC;
      end
      CALC: begin
        step_nxt  = result_c[31:0];
        valid_nxt = 1'b1;
        state_nxt = PUB;
      end
      PUB: begin
        if (step_valid && step_ready) begin
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      op         <= '0;
      step       <= STEP_INIT;
      step_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      op         <= op_nxt;
      step       <= step_nxt;
      step_valid <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_dds_step_controller.sv
// Randomized scoreboard bench for dds_step_controller with a plain-arithmetic
// reference model of the step word.
module tb_dds_step_controller;

  localparam longint INIT = 171798691;
  localparam longint SMAX = 171798691;
  localparam longint SMIN = 858993;
  localparam longint DC   = 858993;
  localparam longint DM   = 85899;
  localparam longint DN   = 85;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  key_n;
  logic        sweep_en;
  logic        step_ready;
  logic [31:0] step;
  logic        step_valid;

  int compared = 0;
  int errors   = 0;
  int n_hs     = 0;
  int n_exp    = 0;
  int rdy_mode = 0;
  longint m;
  longint expq[$];

  dds_step_controller #(.DB_CYCLES(4), .SWEEP_DIV(8)) dut (
    .clk(clk), .reset(reset), .key_n(key_n), .sweep_en(sweep_en),
    .step_ready(step_ready), .step(step), .step_valid(step_valid)
  );

  always #5 clk = ~clk;

  // Ready driver: 0 = always ready, 1 = random, 2 = stalled
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       step_ready = 1'($urandom_range(0, 1));
      2:       step_ready = 1'b0;
      default: step_ready = 1'b1;
    endcase
  end

  function automatic longint key_model(longint s, int k);
    longint d;
    d = (k < 2) ? DC : (k < 4) ? DM : DN;
    if (k % 2 == 0) return (s + d > SMAX) ? SMAX : s + d;
    return (s < SMIN + d) ? SMIN : s - d;
  endfunction

  function automatic longint sweep_model(longint s);
    return (s + DC > SMAX) ? SMIN : s + DC;
  endfunction

  // Monitor: every accepted word is popped and compared; step must hold during PUB
  logic [31:0] held;
  bit pv = 0;
  always @(negedge clk) begin
    if (reset) begin
      pv = 0;
    end else begin
      if (step_valid && !pv) held = step;
      if (step_valid && step_ready) begin
        n_hs++;
        compared++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_publish: got step=%0d, required no publish", step);
        end else begin
          longint e;
          e = expq.pop_front();
          if (longint'(step) != e) begin
            errors++;
            $display("FAIL publish_value: got step=%0d, required %0d", step, e);
          end
        end
        compared++;
        if (step !== held) begin
          errors++;
          $display("FAIL pub_stability: got step=%0d at accept, required %0d held", step, held);
        end
      end
      pv = step_valid;
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(string name, longint got, longint req);
    compared++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic push(longint v);
    expq.push_back(v);
    n_exp++;
  endtask

  task automatic wait_pub(int target);
    int c = 0;
    while (n_hs < target && c < 3000) begin
      tick(1);
      c++;
    end
    check("publish_count", n_hs, target);
  endtask

  task automatic do_reset(string name);
    reset = 1'b1;
    #1;
    check({name, "_step"}, step, INIT);
    check({name, "_valid"}, step_valid, 0);
    key_n = '1;
    sweep_en = 1'b0;
    expq.delete();
    n_exp = n_hs;
    m = INIT;
    tick(4);
    reset = 1'b0;
    tick(2);
  endtask

  task automatic press(logic [5:0] mask, int len);
    key_n = ~mask;
    tick(len);
    key_n = '1;
    tick(12);
  endtask

  initial begin
    reset = 1'b1;
    key_n = '1;
    sweep_en = 1'b0;
    step_ready = 1'b1;
    m = INIT;
    tick(3);
    check("reset_step", step, INIT);
    check("reset_valid", step_valid, 0);
    reset = 1'b0;
    tick(50);
    check("idle_no_publish", n_hs, 0);

    // Short pulse rejected, long press accepted
    press(6'b000010, 3);
    tick(20);
    check("debounce_reject", n_hs, 0);
    m = key_model(m, 1);
    push(m);
    press(6'b000010, 10);
    wait_pub(n_exp);

    // Simultaneous keys from reset, serviced in priority order
    do_reset("reset2");
    m = key_model(m, 0); push(m);
    m = key_model(m, 5); push(m);
    press(6'b100001, 10);
    wait_pub(n_exp);

    // Sweep from reset with a long stall, then reset mid-run
    do_reset("reset3");
    for (int i = 0; i < 6; i++) begin
      m = sweep_model(m);
      push(m);
    end
    sweep_en = 1'b1;
    wait_pub(n_hs + 1);
    rdy_mode = 2;
    tick(30);
    check("stall_valid", step_valid, 1);
    rdy_mode = 1;
    wait_pub(n_exp);
    do_reset("reset4");
    rdy_mode = 0;

    // Two sweep ticks with ready tied high, leaving step near the floor
    for (int i = 0; i < 2; i++) begin
      m = sweep_model(m);
      push(m);
    end
    sweep_en = 1'b1;
    wait_pub(n_exp);
    sweep_en = 1'b0;
    tick(20);

    // Random key batches under random backpressure, with rejected glitches
    rdy_mode = 1;
    for (int b = 0; b < 30; b++) begin
      logic [5:0] mask;
      int g;
      mask = 6'($urandom_range(1, 63));
      g = $urandom_range(0, 5);
      if (!mask[g]) begin
        key_n[g] = 1'b0;
        tick(2);
        key_n[g] = 1'b1;
        tick(6);
      end
      for (int k = 0; k < 6; k++) begin
        if (mask[k]) begin
          m = key_model(m, k);
          push(m);
        end
      end
      press(mask, 10);
      wait_pub(n_exp);
      tick(4);
    end

    // Reset while a word is awaiting acceptance drops it and pending requests
    rdy_mode = 2;
    key_n = ~6'b001001;
    begin
      int c = 0;
      while (!step_valid && c < 200) begin
        tick(1);
        c++;
      end
      check("reach_pub", step_valid, 1);
    end
    do_reset("reset_mid_pub");
    rdy_mode = 0;
    begin
      int base;
      base = n_hs;
      tick(50);
      check("no_publish_after_reset", n_hs, base);
    end
    check("queue_drained", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
    $finish;
  end

endmodule

// File: doc/dds_step_controller.md
# dds_step_controller

Synchronous controller that owns the DDS frequency control word (`step`) and hands it to the phase-accumulator core. It debounces the six panel keys, arbitrates their requests with an optional linear sweep generator, and applies clamped or wrapping arithmetic. Each new word is published to the accumulator over a valid/ready handshake.

## Interface

- `STEP_INIT`, 171798691: reset value of `step` (2 MHz).
- `STEP_MAX`, 171798691: upper clamp.
- `STEP_MIN`, 858993: lower clamp.
- `D_COARSE`, 858993: coarse delta.
- `D_MICRO`, 85899: micro delta.
- `D_NANO`, 85: nano delta.
- `DB_CYCLES`, 500000: cycles a synchronized key level must stay stable before it is accepted.
- `SWEEP_DIV`, 50000: cycles between sweep ticks.

- `clk` input 1: single system clock; all logic is on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `key_n` input 6: raw active-low keys, asynchronous to `clk`.
  - [0] coarse add, [1] coarse sub.
  - [2] micro add, [3] micro sub.
  - [4] nano add, [5] nano sub.
- `sweep_en` input 1: level; enables the sawtooth sweep.
- `step_ready` input 1: DDS core accepts `step`.
- `step` output 32: current frequency control word.
- `step_valid` output 1: `step` holds a new word awaiting acceptance.

## Operation

- **Reset values:**
  - `step` = `STEP_INIT`, `step_valid` = 0, FSM in IDLE.
  - Pending bits cleared; debounced key levels = 1 (released).
  - Debounce and sweep counters = 0.
- **Key path, per bit:**
  - 2-FF synchronizer, then a debounce counter.
  - When the synchronized level differs from the stable level, the counter increments. At `DB_CYCLES`-1 the stable level takes the new value and the counter clears.
  - When the levels match, the counter clears.
  - A 1→0 transition of the stable level sets `pend[i]`.
  - Release generates nothing.
- **Sweep path:**
  - With `sweep_en` = 1, the divider counts 0..`SWEEP_DIV`-1. At the terminal count it sets `pend_sw` and wraps to 0.
  - With `sweep_en` = 0, the divider is held at 0 and `pend_sw` is cleared.
- **Arbitration (fixed priority):**
  - `pend[0]` > `pend[1]` > … > `pend[5]` > `pend_sw`.
  - One request is serviced per update; its pending bit is cleared when IDLE grants it.
  - A pending bit that is already set absorbs repeat events (no counting).
- **FSM:**
  - IDLE: if any pending bit is set, latch the winning opcode, clear that bit, go to CALC.
  - CALC: compute the new `step` in 33-bit arithmetic, register it, set `step_valid`, go to PUB.
  - PUB: hold `step` and `step_valid`. When `step_valid` && `step_ready`, clear `step_valid` and go to IDLE.
- **Arithmetic:**
  - Add: result = min(`step`+delta, `STEP_MAX`).
  - Sub: result = `STEP_MIN` if `step` < `STEP_MIN`+delta, else `step`−delta. Underflow is never wrapped.
  - Sweep: result = `STEP_MIN` if `step`+`D_COARSE` > `STEP_MAX` (sawtooth wrap), else `step`+`D_COARSE`.
  - A clamped result is still published, even if unchanged.
- **Boundary cases:**
  - Simultaneous events are all captured and serviced in priority order, one publish each.
  - Events arriving during CALC or PUB stay pending.
  - `reset` asserted mid-operation immediately forces reset values and drops any unaccepted word.

## Timing

- Raw key edge to debounced edge: 2 synchronizer cycles + `DB_CYCLES`.
- Pending set at cycle E. IDLE grants it at E+1, CALC runs at E+2, and `step` and `step_valid` are high from E+3.
- Handshake completes on the cycle `step_valid` && `step_ready` is sampled high. The next grant can occur in the following cycle.
- Maximum throughput: one update per 3 cycles with `step_ready` tied high.
- `step` changes only on the CALC→PUB edge or on reset; it is stable throughout PUB.

## Test plan

All tests use `DB_CYCLES`=4, `SWEEP_DIV`=8.

1. **Reset:** assert `reset` → `step`=171798691, `step_valid`=0. Release; 50 idle cycles → no publish.
2. **Debounce reject:** `key_n[1]` low for 3 cycles then high, `step_ready`=1 → no publish. Low for 10 cycles → exactly one publish of 170939698.
3. **Clamping at both limits:**
   - From reset, coarse add → publish 171798691 (clamped at max).
   - Drive `step` to 900000, then nano sub → 899915.
   - Then coarse sub → 858993 (clamped at min).
4. **Simultaneous keys:** `key_n[0]` and `key_n[5]` pressed in the same cycle from reset → two publishes in order: 171798691, then 171798606.
5. **Sweep wrap and backpressure:**
   - `sweep_en`=1 from reset → first publish 858993 (wrap), next 1717986.
   - Hold `step_ready`=0 for 30 cycles → `step` and `step_valid` stable, the later tick stays pending and is published after ready.
6. **Reset mid-PUB:** assert `reset` while `step_valid`=1 → `step_valid`=0 and `step`=171798691 immediately. Pending key requests are lost.
